// File: rtl/mock_memory_arb.sv
// Multi-port mock memory: round-robin arbitration onto one shared word array,
// with a programmable grant-to-completion delay and error responses for out-of-range accesses.
module mock_memory_arb #(
    parameter int                    NUM_PORTS  = 2,
    parameter int                    DEPTH      = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_BASE  = DATA_WIDTH'(32'hDEAD0000)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [31:0]                           delay_i,
    input  logic [NUM_PORTS-1:0]                  req_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS-1:0]                  wen_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
    output logic [NUM_PORTS-1:0]                  ready_o,
    output logic [NUM_PORTS-1:0]                  err_o,
    output logic                                  busy_o
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW  = ADDR_WIDTH - OFF;
    localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                          state_q, state_d;
    logic [PW-1:0]                   owner_q, owner_d;
    logic [PW-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [31:0]                     cnt_q, cnt_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

    logic                  any_req;
    logic [PW-1:0]         win;
    logic                  comp_vld;
    logic [PW-1:0]         comp_port;
    logic [IW-1:0]         sel_idx;
    logic                  sel_wen;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [NB-1:0]         sel_be;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_en;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
    endfunction

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        int j;
        any_req = 1'b0;
        win     = '0;
        j       = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!any_req && req_i[j]) begin
                any_req = 1'b1;
                win     = PW'(j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        comp_vld  = 1'b0;
        comp_port = owner_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (delay_i == 32'd0) begin
                        comp_vld  = 1'b1;
                        comp_port = win;
                        rr_ptr_d  = next_port(win);
                    end else begin
                        state_d = BUSY;
                        owner_d = win;
                        cnt_d   = 32'd1;
                    end
                end
            end
            BUSY: begin
                if (!req_i[owner_q]) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                end else if (cnt_q >= delay_i) begin
                    comp_vld  = 1'b1;
                    comp_port = owner_q;
                    state_d   = IDLE;
                    cnt_d     = 32'd0;
                    rr_ptr_d  = next_port(owner_q);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are taken from the completing port in the completion cycle.
    assign sel_idx   = addr_i[comp_port][ADDR_WIDTH-1:OFF];
    assign sel_wen   = wen_i[comp_port];
    assign sel_wdata = wdata_i[comp_port];
    assign sel_be    = be_i[comp_port];
    assign in_range  = ({1'b0, sel_idx} < (IW+1)'(DEPTH));
    assign rd_word   = mem_q[sel_idx[MW-1:0]];
    assign wr_en     = comp_vld && in_range && sel_wen && !rst_i;
    assign busy_o    = (state_q == BUSY) && !rst_i;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign ready_o[p] = comp_vld && (comp_port == PW'(p)) && !rst_i;
        assign err_o[p]   = ready_o[p] && !in_range;
        assign rdata_o[p] = (ready_o[p] && in_range && !sel_wen) ? rd_word : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_BASE + DATA_WIDTH'(i);
            end
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            if (wr_en) begin
                for (int k = 0; k < NB; k++) begin
                    if (sel_be[k]) mem_q[sel_idx[MW-1:0]][k*8 +: 8] <= sel_wdata[k*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_mock_memory_arb.sv
// Directed bench for mock_memory_arb: latency, byte writes, round-robin,
// out-of-range errors, aborts and reset during a pending request.
module tb_mock_memory_arb;
    localparam int NP = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [31:0]             delay_i;
    logic [NP-1:0]           req_i;
    logic [NP-1:0][AW-1:0]   addr_i;
    logic [NP-1:0]           wen_i;
    logic [NP-1:0][DW-1:0]   wdata_i;
    logic [NP-1:0][DW/8-1:0] be_i;
    logic [NP-1:0][DW-1:0]   rdata_o;
    logic [NP-1:0]           ready_o;
    logic [NP-1:0]           err_o;
    logic                    busy_o;

    mock_memory_arb dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .delay_i (delay_i),
        .req_i   (req_i),
        .addr_i  (addr_i),
        .wen_i   (wen_i),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .rdata_o (rdata_o),
        .ready_o (ready_o),
        .err_o   (err_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request on port p and wait (bounded) for its ready pulse.
    task automatic access(input int p, input logic [31:0] a, input logic w,
                          input logic [31:0] wd, input logic [3:0] be, input logic [31:0] dly,
                          output logic [31:0] rd, output logic er, output int lat);
        delay_i    = dly;
        addr_i[p]  = a;
        wen_i[p]   = w;
        wdata_i[p] = wd;
        be_i[p]    = be;
        req_i[p]   = 1'b1;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (ready_o[p]) begin
                lat = c;
                rd  = rdata_o[p];
                er  = err_o[p];
                break;
            end
            next_cyc();
        end
        next_cyc();
        req_i[p] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          first1;
    logic        saw0;
    logic [31:0] rd1;
    logic [1:0]  exp_rdy;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i   = 1'b1;
        delay_i = '0;
        req_i   = '0;
        addr_i  = '0;
        wen_i   = '0;
        wdata_i = '0;
        be_i    = '0;
        // Same-cycle completion must be masked while reset is high
        req_i[0]  = 1'b1;
        addr_i[0] = 32'h8;
        @(negedge clk_i);
        check("rst_ready", ready_o, 2'b00);
        check("rst_rdata0", rdata_o[0], 32'h0);
        check("rst_busy", busy_o, 1'b0);
        next_cyc();
        next_cyc();
        req_i = '0;
        rst_i = 1'b0;

        // delay 0 read
        access(0, 32'h8, 1'b0, 32'h0, 4'h0, 32'd0, rd, er, lat);
        check("d0_lat", lat, 0);
        check("d0_rdata", rd, 32'hDEAD0002);
        check("d0_err", er, 1'b0);

        // delay 3 byte-enabled write, then read back
        access(0, 32'h4, 1'b1, 32'h12345678, 4'b0101, 32'd3, rd, er, lat);
        check("d3_lat", lat, 3);
        check("d3_err", er, 1'b0);
        access(0, 32'h4, 1'b0, 32'h0, 4'h0, 32'd0, rd, er, lat);
        check("be_rdata", rd, 32'hDE340078);

        // Round-robin with delay 1 from reset
        rst_i = 1'b1;
        next_cyc();
        rst_i     = 1'b0;
        delay_i   = 32'd1;
        addr_i[0] = 32'h0;
        addr_i[1] = 32'h4;
        wen_i     = '0;
        req_i     = 2'b11;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk_i);
            exp_rdy = (c == 1 || c == 5) ? 2'b01 : (c == 3 || c == 7) ? 2'b10 : 2'b00;
            check($sformatf("rr_c%0d", c), ready_o, exp_rdy);
            if (c == 1) check("rr_rdata0", rdata_o[0], 32'hDEAD0000);
            if (c == 3) check("rr_rdata1", rdata_o[1], 32'hDEAD0001);
            next_cyc();
        end
        req_i = '0;
        next_cyc();
        @(negedge clk_i);
        check("rr_idle", busy_o, 1'b0);
        next_cyc();

        // Out-of-range write and read on port 1
        access(1, 32'h40, 1'b1, 32'hFFFFFFFF, 4'hF, 32'd2, rd, er, lat);
        check("oor_w_lat", lat, 2);
        check("oor_w_err", er, 1'b1);
        check("oor_w_rdata", rd, 32'h0);
        access(1, 32'h40, 1'b0, 32'h0, 4'h0, 32'd0, rd, er, lat);
        check("oor_r_lat", lat, 0);
        check("oor_r_err", er, 1'b1);
        check("oor_r_rdata", rd, 32'h0);
        for (int i = 0; i < 16; i++) begin
            access(0, 32'(i * 4), 1'b0, 32'h0, 4'h0, 32'd0, rd, er, lat);
            check($sformatf("scan_w%0d", i), rd, 32'hDEAD0000 + 32'(i));
        end

        // Abort: port 0 drops after 2 cycles, port 1 picks up
        delay_i    = 32'd5;
        addr_i[0]  = 32'h0;
        wen_i[0]   = 1'b1;
        wdata_i[0] = 32'hAAAAAAAA;
        be_i[0]    = 4'hF;
        addr_i[1]  = 32'h0;
        wen_i[1]   = 1'b0;
        first1 = -1;
        saw0   = 1'b0;
        rd1    = '0;
        for (int c = 0; c < 14; c++) begin
            req_i[0] = (c < 2);
            req_i[1] = (c >= 2) && (first1 < 0);
            @(negedge clk_i);
            if (ready_o[0]) saw0 = 1'b1;
            if (ready_o[1] && first1 < 0) begin
                first1 = c;
                rd1    = rdata_o[1];
            end
            if (c == 2) check("ab_busy_c2", busy_o, 1'b1);
            if (c == 3) check("ab_busy_c3", busy_o, 1'b0);
            next_cyc();
        end
        req_i = '0;
        check("ab_no_ready0", saw0, 1'b0);
        check("ab_ready1_cyc", first1, 8);
        check("ab_rdata1", rd1, 32'hDEAD0000);

        // Reset during BUSY discards the pending write
        delay_i    = 32'd4;
        addr_i[0]  = 32'h0;
        wen_i[0]   = 1'b1;
        wdata_i[0] = 32'h55555555;
        be_i[0]    = 4'hF;
        req_i[0]   = 1'b1;
        @(negedge clk_i);
        check("rb_c0_ready", ready_o, 2'b00);
        next_cyc();
        @(negedge clk_i);
        check("rb_c1_busy", busy_o, 1'b1);
        next_cyc();
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rb_c2_ready", ready_o, 2'b00);
        check("rb_c2_busy", busy_o, 1'b0);
        next_cyc();
        rst_i = 1'b0;
        req_i = '0;
        @(negedge clk_i);
        check("rb_after_busy", busy_o, 1'b0);
        check("rb_after_ready", ready_o, 2'b00);
        next_cyc();
        access(0, 32'h0, 1'b0, 32'h0, 4'h0, 32'd0, rd, er, lat);
        check("rb_rdata", rd, 32'hDEAD0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mock_memory_arb.md
# mock_memory_arb

Parametrised multi-port mock memory for crossbar and interconnect testbenches. It serves NUM_PORTS request ports from one shared word array using round-robin arbitration. Each accepted request completes after a runtime-programmable delay. Out-of-range accesses complete with an error flag and have no side effects. The block sits behind the crossbar's target side in DV benches and supports multi-master contention, aborted requests and error responses.

## Interface
Parameters:
- NUM_PORTS, 2, number of request ports (≥1)
- DEPTH, 16, number of memory words (≥1)
- DATA_WIDTH, 32, word width in bits (multiple of 8, ≥8)
- ADDR_WIDTH, 32, byte-address width; must be ≥ log2(DATA_WIDTH/8)+clog2(DEPTH)
- INIT_BASE, 'hDEAD0000, reset content base; word i resets to INIT_BASE+i, truncated to DATA_WIDTH

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- delay_i  in  32  cycles from grant to completion (0 = same-cycle completion)
- req_i  in  [NUM_PORTS]  per-port request, held until ready_o
- addr_i  in  [NUM_PORTS][ADDR_WIDTH]  byte address
- wen_i  in  [NUM_PORTS]  1 = write, 0 = read
- wdata_i  in  [NUM_PORTS][DATA_WIDTH]  write data
- be_i  in  [NUM_PORTS][DATA_WIDTH/8]  byte enables, writes only
- rdata_o  out  [NUM_PORTS][DATA_WIDTH]  read data, valid only with ready_o
- ready_o  out  [NUM_PORTS]  one-cycle completion pulse
- err_o  out  [NUM_PORTS]  out-of-range flag, valid only with ready_o
- busy_o  out  1  high while in BUSY

## Operation
- Word index = addr_i[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]. Low address bits are ignored. The request is in range iff index < DEPTH.
- FSM states: IDLE, BUSY. Registers: owner, cnt (32 bit), rr_ptr.
- Arbitration in IDLE:
  - The winner is the first requesting port searching from rr_ptr upward, wrapping around.
  - If delay_i==0, the winner completes in the same cycle, rr_ptr becomes winner+1 (mod NUM_PORTS), and the FSM stays in IDLE.
  - Otherwise the FSM goes to BUSY with owner=winner and cnt=1.
- BUSY:
  - If req_i[owner]==0, the request aborts: the FSM goes to IDLE, cnt=0, rr_ptr is unchanged, and there is no memory effect and no ready_o.
  - Else if cnt ≥ delay_i, the request completes: the FSM goes to IDLE and rr_ptr becomes owner+1. Using ≥ means a delay_i lowered mid-request completes at once.
  - Else cnt increments.
  - Other ports' requests are ignored while BUSY.
- Completion for port p:
  - ready_o[p]=1 for exactly that cycle.
  - In range, write: bytes with be_i[p][k]=1 are written at the clock edge. be_i=0 completes with no change.
  - In range, read: rdata_o[p] = current word (pre-edge content).
  - Out of range: err_o[p]=1, rdata_o[p]=0, no write.
- At most one completion per cycle, so there are no write conflicts.
- rdata_o, err_o and ready_o are 0 on every port not completing in that cycle.
- Request fields (addr_i, wen_i, wdata_i, be_i) are sampled on the completion cycle. Changing them while waiting is legal; the values at completion are used.

## Timing
- Reset (rst_i high at a clock edge):
  - FSM goes to IDLE; cnt=0, owner=0, rr_ptr=0.
  - Memory is re-initialised to INIT_BASE+i.
  - All outputs are forced to 0 combinationally while rst_i is high, including any same-cycle completion.
- Reset mid-BUSY discards the pending request; its write is not performed.
- Latency from the first cycle a port is granted:
  - delay_i=0: ready_o in that cycle.
  - delay_i=N: ready_o N cycles later.
- Back-to-back requests from one port with delay_i=0 complete every cycle.
- With delay_i=N>0, each completion is followed by one IDLE cycle in which the next grant happens. Throughput is therefore one access per N+1 cycles.
- A port that keeps req_i high after its ready_o starts a new request.

## Test plan
- Reset, delay_i=0, port0 reads addr 'h8 -> same cycle: ready_o[0]=1, rdata_o[0]='hDEAD0002, err_o[0]=0.
- delay_i=3, port0 writes addr 'h4, wdata 'h12345678, be 'b0101, held -> ready_o[0] in the 4th request cycle. A subsequent read of 'h4 returns 'hDE340078.
- delay_i=1, both ports request from reset, held:
  - ready_o[0] at cycle 1 and ready_o[1] at cycle 3.
  - Never both high at once.
  - Alternation continues: p0 at 5, p1 at 7.
- Port1 accesses addr 'h40 (index 16) as both a write and a read:
  - ready_o[1]=1, err_o[1]=1, rdata_o[1]=0.
  - Reading all 16 words afterwards shows the reset values unchanged.
- Abort: delay_i=5, port0 requests for 2 cycles then drops, port1 requests from cycle 2:
  - No ready_o[0], and no write effect from port0.
  - ready_o[1] 5 cycles after port1's grant.
- Port0 write to addr 0 with delay_i=4; rst_i pulsed in BUSY cycle 2:
  - No ready_o.
  - busy_o=0 after the reset edge.
  - Read of addr 0 returns 'hDEAD0000.
